acc_start_ctrl: RTL and testbench
=================================

Name: acc_start_ctrl

Overview:
- Sits directly downstream of the 1-bit "start" PIO output register; consumes its level and runs one accelerator job per 0->1 transition.
- Converts the software-written start level into a single-cycle go pulse.
- Tracks the job until the accelerator reports done or a timeout expires.
- Publishes a 32-bit status word, to be wired to a PIO input port, for software polling.

Parameters:
- TIMEOUT_CYCLES, 50000: RUN-state cycles before a job is declared timed out. Legal range 2..2^24-1.
- CNT_W, 24: width of the job-duration counter reported in status[31:8]. Fixed at 24.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- start_in  in  1  start level from the PIO output register
- acc_go  out  1  one-cycle launch pulse to the accelerator
- acc_done  in  1  accelerator completion; pulse or level, sampled in RUN only
- busy  out  1  high while a job is launched or running (GO or RUN)
- status  out  32  {cycles[23:0], 5'b0, timeout, done, busy}
- irq  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset: one clock, synchronous, active-low; all state is updated only on the rising edge of clk.
- Reset values: state=IDLE, acc_go=0, busy=0, done=0, timeout=0, cycles=0, irq=0.
- start_q resets to 1, so a start_in held high through reset release does not launch a job.
- Edge detect: start_q <= start_in every cycle; rise = start_in & ~start_q.
- IDLE:
  - On rise: go to GO; clear done, timeout and cycles in the same edge.
  - Otherwise stay in IDLE.
- GO:
  - acc_go=1 for exactly this one cycle; busy=1.
  - Unconditionally go to RUN next cycle. acc_done is ignored in GO.
- RUN: busy=1; each cycle the first matching case applies:
  - acc_done=1: set done; go to WAIT_LOW.
  - Else cycles==TIMEOUT_CYCLES-1: set timeout; go to WAIT_LOW.
  - Else cycles <= cycles+1, saturating at 2^24-1.
  - acc_done and timeout in the same cycle: done wins; timeout stays 0.
  - cycles freezes on exit and holds the job duration in RUN cycles, excluding the GO cycle.
- WAIT_LOW:
  - busy=0; stay until start_in==0, then go to IDLE.
  - The job is not re-armed while start is held high.
  - A start pulse that goes high->low inside RUN still completes the job normally.
  - With start_in already low on entry, the FSM exits to IDLE after one cycle.
- Rise during GO/RUN/WAIT_LOW: ignored, not queued.
- Status bits:
  - status[0] is combinational from state (GO or RUN).
  - status[1], status[2] and status[31:8] are registered and hold until the next launch.
  - status[7:3]=0.
- Reset mid-job: FSM returns to IDLE and clears all status. No abort is signalled to the accelerator; software must reset it separately.
- Latency: rise on start_in at edge N gives acc_go high in cycle N+1. busy rises with acc_go.

Optional Feature:
- Macro: ACC_START_CTRL_IRQ_EN.
- Defined:
  - irq is a registered level, set on the edge that sets done or timeout.
  - irq is cleared on the next launch (IDLE->GO) or by reset.
  - irq is independent of start_in.
- Undefined: irq is tied to constant 0 and no irq register is generated.

Test Plan:
- Basic job: start_in 0->1; acc_done pulse 10 cycles after acc_go.
  - Required: acc_go high exactly 1 cycle.
  - Required: status=0x00000A02 after done; busy=0; irq=1 if IRQ_EN.
- Timeout: TIMEOUT_CYCLES=20, acc_done never asserted.
  - Required: timeout=1, done=0, cycles=19, status=0x00001304, FSM in WAIT_LOW.
- Simultaneous events: acc_done asserted on the cycle with cycles==TIMEOUT_CYCLES-1.
  - Required: done=1, timeout=0.
- Re-arm and ignore:
  - Hold start high after done, apply toggles on acc_done -> no second acc_go.
  - Drop start to 0 then raise to 1 -> exactly one new acc_go, and status clears to 0x00000001 on the GO cycle.
- Reset polarity/sync:
  - start_in=1 across reset release -> no acc_go.
  - reset_n low mid-RUN for 1 cycle (sampled on an edge) -> all outputs 0 and IDLE next cycle.
  - reset_n glitch low between edges -> no effect.
- Saturation: TIMEOUT_CYCLES=2^24-1, no done.
  - Required: cycles never wraps; timeout sets with cycles=0xFFFFFE.

Source files
------------

// File: rtl/acc_start_ctrl_if.sv
// ----------------------------------------------------------------------------
// acc_start_ctrl_if
//   Bundles the signals between the start PIO, the accelerator and the
//   status PIO input port into one interface around acc_start_ctrl.
//
//   Signals:
//     start_in  start level from the PIO output register
//     acc_go    one-cycle launch pulse to the accelerator
//     acc_done  accelerator completion (pulse or level)
//     busy      high while a job is launched or running
//     status    {cycles[23:0], 5'b0, timeout, done, busy}
//     irq       completion interrupt (constant 0 unless ACC_START_CTRL_IRQ_EN)
//
//   Modports:
//     master  the controller side (drives acc_go, busy, status, irq)
//     slave   the environment side (drives start_in, acc_done)
// ----------------------------------------------------------------------------
interface acc_start_ctrl_if;
    logic        start_in;
    logic        acc_go;
    logic        acc_done;
    logic        busy;
    logic [31:0] status;
    logic        irq;

    modport master (
        input  start_in,
        input  acc_done,
        output acc_go,
        output busy,
        output status,
        output irq
    );

    modport slave (
        output start_in,
        output acc_done,
        input  acc_go,
        input  busy,
        input  status,
        input  irq
    );
endinterface

// File: rtl/acc_start_ctrl.sv
// ----------------------------------------------------------------------------
// acc_start_ctrl
//   Turns the software-written start level into a single-cycle accelerator
//   launch pulse, tracks the job until the accelerator reports done or a
//   timeout expires, and publishes a 32-bit status word for polling.
//
//   Parameters:
//     TIMEOUT_CYCLES  RUN cycles before a job is declared timed out (2..2^24-1)
//     CNT_W           width of the job-duration counter (fixed at 24)
//
//   Ports:
//     clk      system clock
//     reset_n  synchronous active-low reset
//     bus      acc_start_ctrl_if.master (start_in, acc_go, acc_done, busy,
//              status, irq)
//
//   Optional feature:
//     ACC_START_CTRL_IRQ_EN  when defined, irq is a registered level set on
//                            job completion/timeout and cleared on the next
//                            launch; when undefined, irq is constant 0.
// ----------------------------------------------------------------------------
module acc_start_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    acc_start_ctrl_if.master        bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GO       = 2'd1,
        RUN      = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic             start_q;
    logic             go_q;
    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cycles;
    logic             rise;
    logic             active;

    assign rise   = bus.start_in & ~start_q;
    assign active = (state == GO) || (state == RUN);

    // NOTE: the reset branch sits inside the clocked block, so reset_n is only
    // seen on a rising edge; a low glitch between edges has no effect.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            // Reset to 1 so a start level held high through reset release is
            // not mistaken for a fresh rising edge.
            start_q   <= 1'b1;
            go_q      <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cycles    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of state, cycles and start_q.
            start_q <= bus.start_in;
            go_q    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= GO;
                        go_q      <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        cycles    <= '0;
                    end
                end
                GO: begin
                    // acc_done is deliberately ignored during the launch cycle.
                    state <= RUN;
                end
                RUN: begin
                    // Completion takes priority over timeout on the same cycle.
                    if (bus.acc_done) begin
                        done_q <= 1'b1;
                        state  <= WAIT_LOW;
                    end else if (cycles == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= WAIT_LOW;
                    end else if (cycles != CNT_MAX) begin
                        cycles <= cycles + 1'b1;
                    end
                end
                WAIT_LOW: begin
                    // No re-arm until software drops start.
                    if (!bus.start_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACC_START_CTRL_IRQ_EN
    logic irq_q;

    // Set on the same edge that sets done or timeout, cleared on launch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (state == IDLE && rise) begin
            irq_q <= 1'b0;
        end else if (state == RUN && (bus.acc_done || cycles == TO_LAST)) begin
            irq_q <= 1'b1;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

    assign bus.acc_go = go_q;
    assign bus.busy   = active;
    assign bus.status = {cycles, 5'b0, timeout_q, done_q, active};

endmodule

// File: tb/tb_acc_start_ctrl.sv
// ----------------------------------------------------------------------------
// tb_acc_start_ctrl
//   Self-checking bench for acc_start_ctrl with TIMEOUT_CYCLES=20. Each job
//   pushes its expected completion status onto a scoreboard queue when the
//   start stimulus is driven; the entry is popped and compared once the DUT
//   drops busy.
// ----------------------------------------------------------------------------
module tb_acc_start_ctrl;

    localparam int unsigned TO = 20;

`ifdef ACC_START_CTRL_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    typedef struct {
        string       tag;
        logic [31:0] status;
        logic        irq;
    } exp_t;

    logic clk;
    logic reset_n;
    acc_start_ctrl_if bus ();

    acc_start_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    // acc_go pulse bookkeeping, sampled on the falling edge.
    int go_cnt     = 0;
    int go_run     = 0;
    int go_run_max = 0;
    always @(negedge clk) begin
        if (bus.acc_go) begin
            go_cnt = go_cnt + 1;
            go_run = go_run + 1;
            if (go_run > go_run_max) go_run_max = go_run;
        end else begin
            go_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input string tag, input int done_after);
        exp_t        e;
        logic [23:0] cyc;
        logic        dn;
        logic        to;
        if (done_after >= 0 && done_after <= int'(TO) - 1) begin
            cyc = 24'(done_after);
            dn  = 1'b1;
            to  = 1'b0;
        end else begin
            cyc = 24'(TO - 1);
            dn  = 1'b0;
            to  = 1'b1;
        end
        e.tag    = tag;
        e.status = {cyc, 5'b0, to, dn, 1'b0};
        e.irq    = IRQ_EXP;
        return e;
    endfunction

    // One job: raise start, optionally drop it during RUN, assert acc_done when
    // the RUN counter equals done_after (-1 = never), optionally glitch reset.
    task automatic run_job(input string tag, input int done_after,
                           input bit short_start, input bit glitch);
        exp_t e;
        int   go_before;
        int   k;
        int   budget;
        sb.push_back(model(tag, done_after));
        go_before    = go_cnt;
        budget       = int'(TO) + 10;
        bus.start_in = 1'b1;
        tick();
        check({tag, "_go"},        32'(bus.acc_go), 32'd1);
        check({tag, "_go_status"}, bus.status,      32'h0000_0001);
        check({tag, "_go_irq"},    32'(bus.irq),    32'd0);
        if (short_start) bus.start_in = 1'b0;
        tick();
        check({tag, "_go_width"}, 32'(bus.acc_go), 32'd0);
        k = 0;
        while (bus.busy && k < budget) begin
            bus.acc_done = (k == done_after);
            if (glitch && k == 3) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            tick();
            k++;
        end
        bus.acc_done = 1'b0;
        check({tag, "_bounded"}, 32'(k < budget), 32'd1);
        e = sb.pop_front();
        check({e.tag, "_status"},  bus.status,      e.status);
        check({e.tag, "_irq"},     32'(bus.irq),    32'(e.irq));
        check({e.tag, "_one_go"},  32'(go_cnt),     32'(go_before + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_hold;

        // Reset with start held high; release must not launch a job.
        reset_n      = 1'b0;
        bus.start_in = 1'b1;
        bus.acc_done = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        check("rst_status", bus.status,      32'h0);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_go",     32'(bus.acc_go), 32'd0);
        check("rst_irq",    32'(bus.irq),    32'd0);
        repeat (4) tick();
        check("rst_no_launch", 32'(go_cnt), 32'd0);
        bus.start_in = 1'b0;
        tick();

        // Basic job: done after 10 RUN cycles -> 0x00000A02.
        run_job("basic", 10, 1'b0, 1'b0);
        check("basic_abs_status", bus.status, 32'h0000_0A02);
        check("basic_busy",       32'(bus.busy), 32'd0);

        // Start still high: acc_done toggles must not relaunch or alter status.
        go_hold = go_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.acc_done = i[0];
            tick();
        end
        bus.acc_done = 1'b0;
        check("hold_no_go",  32'(go_cnt),  32'(go_hold));
        check("hold_status", bus.status,   32'h0000_0A02);

        // Drop start, then re-arm: exactly one new launch.
        bus.start_in = 1'b0;
        tick();
        run_job("rearm", 2, 1'b0, 1'b0);
        bus.start_in = 1'b0;
        tick();

        // Timeout with acc_done never asserted -> 0x00001304, left in WAIT_LOW.
        run_job("timeout", -1, 1'b0, 1'b0);
        check("timeout_abs_status", bus.status, 32'h0000_1304);
        tick();
        check("timeout_wait_low", 32'(bus.busy), 32'd0);
        bus.start_in = 1'b0;
        tick();

        // acc_done on the cycle the counter reaches TIMEOUT_CYCLES-1: done wins.
        run_job("simul", int'(TO) - 1, 1'b0, 1'b0);
        check("simul_abs_status", bus.status, 32'h0000_1302);
        bus.start_in = 1'b0;
        tick();

        // Short start pulse dropped during RUN still completes; WAIT_LOW exits.
        run_job("short", 5, 1'b1, 1'b0);
        tick();
        run_job("after_short", 1, 1'b0, 1'b0);
        bus.start_in = 1'b0;
        tick();

        // Reset glitch between edges is ignored.
        run_job("glitch", 6, 1'b0, 1'b1);
        bus.start_in = 1'b0;
        tick();

        // Rise during RUN is ignored and not queued.
        go_hold      = go_cnt;
        bus.start_in = 1'b1;
        tick();
        tick();
        bus.start_in = 1'b0;
        tick();
        bus.start_in = 1'b1;
        tick();
        bus.acc_done = 1'b1;
        tick();
        bus.acc_done = 1'b0;
        bus.start_in = 1'b0;
        repeat (3) tick();
        check("rise_in_run_ignored", 32'(go_cnt), 32'(go_hold + 1));
        check("rise_in_run_status",  bus.status,  32'h0000_0202);

        // Synchronous reset mid-RUN clears everything; start held high.
        bus.start_in = 1'b1;
        repeat (5) tick();
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        go_hold = go_cnt;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_status", bus.status,      32'h0);
        check("mid_rst_busy",   32'(bus.busy),   32'd0);
        check("mid_rst_go",     32'(bus.acc_go), 32'd0);
        check("mid_rst_irq",    32'(bus.irq),    32'd0);
        repeat (3) tick();
        check("mid_rst_no_launch", 32'(go_cnt), 32'(go_hold));

        check("go_max_width", 32'(go_run_max), 32'd1);
        check("sb_empty",     32'(sb.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
